// File: rtl/acc16_datapath_if.sv
// rtl/acc16_datapath_if.sv - controller strobes, operands and committed result of the accumulator datapath
interface acc16_datapath_if #(
  parameter int DW    = 8,
  parameter int ACC_W = 16
);
  logic                    en;
  logic                    sel;
  logic                    flush;
  logic signed [DW-1:0]    x;
  logic signed [DW-1:0]    w;
  logic signed [ACC_W-1:0] y;
  logic                    y_valid;
  logic                    y_sat;
  logic                    cnt_err;
  logic                    busy;

  // controller / next-stage side
  modport master (
    output en, sel, flush, x, w,
    input  y, y_valid, y_sat, cnt_err, busy
  );

  // datapath side
  modport slave (
    input  en, sel, flush, x, w,
    output y, y_valid, y_sat, cnt_err, busy
  );
endinterface

// File: rtl/acc16_datapath.sv
// rtl/acc16_datapath.sv - signed multiply-accumulate with saturation, term counting and optional ReLU commit
module acc16_datapath #(
  parameter int DW      = 8,
  parameter int ACC_W   = 16,
  parameter int N_TERMS = 16,
  parameter int RELU    = 1
) (
  input  logic             clk,
  input  logic             rst,
  acc16_datapath_if.slave  bus
);
  localparam int PW = 2 * DW;
  localparam int CW = $clog2(N_TERMS + 2);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_ACC  = 1'b1;

  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(N_TERMS);
  localparam logic [CW-1:0] CNT_MAX  = CW'(N_TERMS + 1);

  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  logic [0:0]              state;
  logic signed [ACC_W-1:0] acc;
  logic [CW-1:0]           cnt;
  logic                    sat_flag;

  logic signed [PW-1:0]    prod;
  logic signed [ACC_W-1:0] p_ext;
  logic signed [ACC_W:0]   sum_wide;
  logic signed [ACC_W-1:0] sum_clamped;
  logic                    ovf;
  logic [CW-1:0]           cnt_inc;
  logic                    do_commit;
  logic signed [ACC_W-1:0] commit_val;

  // product, one-bit-wider sum and clamp back into the accumulator range
  always_comb begin
    prod        = PW'(bus.x) * PW'(bus.w);
    p_ext       = ACC_W'(prod);
    sum_wide    = (ACC_W+1)'(acc) + (ACC_W+1)'(p_ext);
    ovf         = sum_wide[ACC_W] != sum_wide[ACC_W-1];
    sum_clamped = sum_wide[ACC_W-1:0];
    if (ovf) begin
      sum_clamped = sum_wide[ACC_W] ? ACC_MIN : ACC_MAX;
    end
    cnt_inc    = (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;
    do_commit  = (state == S_ACC) && (bus.flush || (bus.en && bus.sel));
    commit_val = ((RELU != 0) && acc[ACC_W-1]) ? '0 : acc;
  end

  // group state: flush closes, sel opens/restarts, plain en accumulates
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= S_IDLE;
      acc      <= '0;
      cnt      <= '0;
      sat_flag <= 1'b0;
    end else if (bus.flush) begin
      state <= S_IDLE;
    end else if (bus.en && bus.sel) begin
      state    <= S_ACC;
      acc      <= p_ext;
      cnt      <= CNT_ONE;
      sat_flag <= 1'b0;
    end else if (bus.en && (state == S_ACC)) begin
      acc      <= sum_clamped;
      cnt      <= cnt_inc;
      sat_flag <= sat_flag | ovf;
    end
  end

  // commit register: result and status of the group that just closed
  always_ff @(posedge clk) begin
    if (!rst) begin
      bus.y       <= '0;
      bus.y_valid <= 1'b0;
      bus.y_sat   <= 1'b0;
      bus.cnt_err <= 1'b0;
    end else begin
      bus.y_valid <= do_commit;
      if (do_commit) begin
        bus.y       <= commit_val;
        bus.y_sat   <= sat_flag;
        bus.cnt_err <= (cnt != CNT_FULL);
      end
    end
  end

  assign bus.busy = (state == S_ACC);
endmodule

// File: doc/acc16_datapath.md
Name: acc16_datapath

Overview:
Accumulator datapath driven by the en/sel strobes of the 16-term accumulation controller (acc_ctrl16). Each enabled cycle it multiplies a signed activation by a signed weight. The product either starts a new sum (sel=1) or is added to the running sum (sel=0). When a group closes, it registers the neuron pre-activation, with optional ReLU, saturation and term-count status, for the next layer stage.

Parameters:
DW, 8, width of signed x and w inputs
ACC_W, 16, width of signed accumulator and result; must satisfy ACC_W >= 2*DW
N_TERMS, 16, expected number of products per group
RELU, 1, 1 = clamp negative results to 0 on output; 0 = pass signed result

Ports:
clk  in  1  system clock, rising-edge
rst  in  1  synchronous, active-low reset
en  in  1  controller enable; 0 = hold all state
sel  in  1  controller select; 1 = load (start new group), 0 = accumulate
flush  in  1  close open group without starting a new one; not gated by en
x  in  DW  signed activation
w  in  DW  signed weight
y  out  ACC_W  committed result, held until next commit
y_valid  out  1  one-cycle pulse: y/y_sat/cnt_err just updated
y_sat  out  1  saturation occurred in committed group
cnt_err  out  1  committed group term count != N_TERMS
busy  out  1  group open (state ACC)

Behaviour:
- Reset (rst=0 at clk edge): state=IDLE, acc=0, cnt=0, sat_flag=0, y=0, y_valid=0, y_sat=0, cnt_err=0, busy=0. A mid-group reset discards the partial sum and produces no y_valid.
- p = x*w, full 2*DW signed product, sign-extended to ACC_W. sum = acc + p computed at ACC_W+1 bits, then clamped to [-2^(ACC_W-1), 2^(ACC_W-1)-1]. Any clamp sets sticky sat_flag. Accumulation continues from the clamped value.
- cnt counts terms in the open group and saturates at N_TERMS+1. cnt width is clog2(N_TERMS+2).
- States: IDLE, ACC. busy = (state==ACC).
- Priority per cycle: rst > flush > en&sel > en&~sel > hold.
- flush=1: if ACC, commit and go to IDLE. If IDLE, no effect. en/sel/x/w are ignored that cycle.
- en=1, sel=1, IDLE: acc<=p, cnt<=1, sat_flag<=0, go to ACC. No commit.
- en=1, sel=1, ACC: commit the old group, then in the same edge acc<=p, cnt<=1, sat_flag<=0, stay in ACC. Back-to-back groups lose no cycle.
- en=1, sel=0, ACC: acc<=clamp(acc+p), cnt<=cnt+1 (saturating), sat_flag|=overflow.
- en=1, sel=0, IDLE: ignored (no state change).
- en=0 (no flush): everything holds. x/w are don't-care.
- Commit (registered, same edge as the triggering cycle):
  - y <= (RELU && acc<0) ? 0 : acc
  - y_sat <= sat_flag
  - cnt_err <= (cnt != N_TERMS)
  - y_valid <= 1
- y_valid is 1 for exactly one cycle after each commit, else 0. Two consecutive commit cycles give two consecutive pulses.
- Latency: last term presented in cycle k; closing sel=1 or flush in cycle k+1; y_valid visible in cycle k+2.
- ReLU never sets y_sat. The reported y_sat reflects accumulator saturation only.

Test Plan:
1. Reset, then sel=1 with x=3,w=4, then 15 cycles sel=0 with x=3,w=4, then sel=1 with x=1,w=1 -> y=192, y_valid one cycle, y_sat=0, cnt_err=0, busy stays 1. Flush next -> y=1, cnt_err=1.
2. Saturation with 16 terms x=127,w=127 -> y=32767, y_sat=1. With 16 terms x=-128,w=127: RELU=1 -> y=0, y_sat=1; RELU=0 -> y=16'h8000, y_sat=1.
3. Repeat scenario 1 with en=0 cycles (x=100,w=100) inserted between terms -> y=192 unchanged, no extra y_valid.
4. Short group of 5 terms x=3,w=4 then sel=1 -> y=60, cnt_err=1. A 17-term group -> cnt_err=1.
5. 16 terms, then flush=1 with en=1,sel=1 in the same cycle -> commit y=192, state IDLE, busy=0. Following sel=0 terms are ignored, and the next sel=1 produces no y_valid.
6. rst=0 after 8 terms -> y=0, y_valid never asserted, busy=0. A fresh 16-term x=3,w=4 group then gives y=192 (no contamination).
